or_gate_4bit: RTL and testbench

- Bitwise OR of two WIDTH-bit operands. Default WIDTH is 4.
- Leaf gate in the integer ALU logic-op path.
- Primary output o is purely combinational.
- A registered copy plus status flags are provided for pipelined consumers, on one clock with asynchronous active-low reset.

---
 rtl/logic_ops_pkg.sv | 32 +++
 rtl/or_gate_bit.sv | 16 +
 rtl/or_gate_4bit.sv | 82 ++++++++
 tb/tb_or_gate_4bit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_ops_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_ops_pkg
// Brief    : Shared constants and helpers for the integer ALU logic-op gates.
// Revision : 1.0
// ============================================================================
package logic_ops_pkg;

    localparam int LOGIC_W = 4;

    // Ceiling log2 used to size counters that must hold the value v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((r < 31) && ((1 << r) < v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width-generic population count; callers zero-extend narrower vectors.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage : logic_ops_pkg
`default_nettype wire

// File: rtl/or_gate_bit.sv
`default_nettype none
// ============================================================================
// Module   : or_gate_bit
// Brief    : Single-bit OR cell.
// Revision : 1.0
// ============================================================================
module or_gate_bit (
    input  logic a,
    input  logic b,
    output logic o
);

    assign o = a | b;

endmodule : or_gate_bit
`default_nettype wire

// File: rtl/or_gate_4bit.sv
`default_nettype none
// ============================================================================
// Module   : or_gate_4bit
// Brief    : WIDTH-bit OR with combinational result plus registered copy,
//            any/change flags. OR_GATE_STATS_EN adds registered popcount cnt_q.
// Revision : 1.0
// ============================================================================
module or_gate_4bit
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = LOGIC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_q,
    output logic             any_q,
    output logic             chg_q
`ifdef OR_GATE_STATS_EN
    ,
    output logic [clog2(WIDTH+1)-1:0] cnt_q
`endif
);

    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] r_o_q;
    logic             r_any_q;
    logic             r_chg_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            or_gate_bit u_bit (
                .a (x[gi]),
                .b (y[gi]),
                .o (w_or[gi])
            );
        end
    endgenerate

    // Result path is independent of clk and rst_n, so it stays valid in reset.
    assign o = w_or;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o_q   <= '0;
            r_any_q <= 1'b0;
            r_chg_q <= 1'b0;
        end else begin
            r_o_q   <= w_or;
            r_any_q <= |w_or;
            r_chg_q <= (w_or != r_o_q);
        end
    end

    assign o_q   = r_o_q;
    assign any_q = r_any_q;
    assign chg_q = r_chg_q;

`ifdef OR_GATE_STATS_EN
    localparam int c_CNT_W = clog2(WIDTH + 1);

    logic [c_CNT_W-1:0] w_pop;
    logic [c_CNT_W-1:0] r_cnt_q;

    assign w_pop = c_CNT_W'(popcount(32'(w_or)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_pop;
        end
    end

    assign cnt_q = r_cnt_q;
`endif

endmodule : or_gate_4bit
`default_nettype wire

// File: tb/tb_or_gate_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_or_gate_4bit
// Brief    : Self-checking bench for or_gate_4bit against a cycle-level model.
// Revision : 1.0
// ============================================================================
module tb_or_gate_4bit;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] o;
    logic [W-1:0] o_q;
    logic         any_q;
    logic         chg_q;
`ifdef OR_GATE_STATS_EN
    logic [2:0]   cnt_q;
`endif

    int checks;
    int errors;

    // Reference model: what the registered outputs should hold right now.
    logic [W-1:0] m_oq;
    logic         m_any;
    logic         m_chg;
    int           m_cnt;

    or_gate_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .o     (o),
        .o_q   (o_q),
        .any_q (any_q),
        .chg_q (chg_q)
`ifdef OR_GATE_STATS_EN
        ,
        .cnt_q (cnt_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_oq  = '0;
        m_any = 1'b0;
        m_chg = 1'b0;
        m_cnt = 0;
    endtask

    // Advance one rising edge, update the model from the value captured there.
    task automatic step();
        logic [W-1:0] cap;
        @(posedge clk);
        cap = x | y;
        if (rst_n) begin
            m_chg = (cap != m_oq);
            m_oq  = cap;
            m_any = (cap != 0);
            m_cnt = $countones(cap);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        x = 4'b1111;
        y = 4'b0000;
        model_reset();
        #1;
        checks++;
        if (o !== 4'b1111) begin errors++; $display("FAIL reset_comb got %b want %b", o, 4'b1111); end
        step();
        step();
        checks++;
        if (o_q !== 4'b0000 || any_q !== 1'b0 || chg_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got o_q=%b any=%b chg=%b want 0000/0/0", o_q, any_q, chg_q);
        end
`ifdef OR_GATE_STATS_EN
        checks++;
        if (cnt_q !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt_q); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (o_q !== 4'b1111 || any_q !== 1'b1 || chg_q !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got o_q=%b any=%b chg=%b want 1111/1/1", o_q, any_q, chg_q);
        end
    endtask

    task automatic test_ones();
        x = 4'b1111;
        y = 4'b0000;
        #1;
        checks++;
        if (o !== 4'b1111) begin errors++; $display("FAIL ones_comb got %b want 1111", o); end
        step();
        checks++;
        if (o_q !== 4'b1111 || chg_q !== 1'b0 || any_q !== 1'b1) begin
            errors++;
            $display("FAIL ones_hold got o_q=%b any=%b chg=%b want 1111/1/0", o_q, any_q, chg_q);
        end
    endtask

    task automatic test_swap();
        x = 4'b0000;
        y = 4'b1111;
        #1;
        checks++;
        if (o !== 4'b1111) begin errors++; $display("FAIL swap_comb got %b want 1111", o); end
        step();
        checks++;
        if (o_q !== 4'b1111 || chg_q !== 1'b0) begin
            errors++;
            $display("FAIL swap_reg got o_q=%b chg=%b want 1111/0", o_q, chg_q);
        end
    endtask

    task automatic test_partial();
        x = 4'b0000;
        y = 4'b0110;
        #1;
        checks++;
        if (o !== 4'b0110) begin errors++; $display("FAIL partial_comb got %b want 0110", o); end
        step();
        checks++;
        if (o_q !== 4'b0110 || chg_q !== 1'b1 || any_q !== 1'b1) begin
            errors++;
            $display("FAIL partial_reg got o_q=%b any=%b chg=%b want 0110/1/1", o_q, any_q, chg_q);
        end
`ifdef OR_GATE_STATS_EN
        checks++;
        if (cnt_q !== 3'd2) begin errors++; $display("FAIL partial_cnt got %0d want 2", cnt_q); end
`endif
    endtask

    task automatic test_zero_midreset();
        x = 4'b0000;
        y = 4'b0000;
        #1;
        checks++;
        if (o !== 4'b0000) begin errors++; $display("FAIL zero_comb got %b want 0000", o); end
        step();
        checks++;
        if (o_q !== 4'b0000 || any_q !== 1'b0 || chg_q !== 1'b1) begin
            errors++;
            $display("FAIL zero_reg got o_q=%b any=%b chg=%b want 0000/0/1", o_q, any_q, chg_q);
        end
        x = 4'b0011;
        step();
        checks++;
        if (o_q !== 4'b0011) begin errors++; $display("FAIL premid_reg got %b want 0011", o_q); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (o_q !== 4'b0000 || any_q !== 1'b0 || chg_q !== 1'b0) begin
            errors++;
            $display("FAIL midreset got o_q=%b any=%b chg=%b want 0000/0/0", o_q, any_q, chg_q);
        end
`ifdef OR_GATE_STATS_EN
        checks++;
        if (cnt_q !== 3'd0) begin errors++; $display("FAIL midreset_cnt got %0d want 0", cnt_q); end
`endif
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (o_q !== 4'b0011 || chg_q !== 1'b1 || any_q !== 1'b1) begin
            errors++;
            $display("FAIL midreset_release got o_q=%b any=%b chg=%b want 0011/1/1", o_q, any_q, chg_q);
        end
    endtask

    task automatic test_overlap();
        x = 4'b1010;
        y = 4'b0110;
        #1;
        checks++;
        if (o !== 4'b1110) begin errors++; $display("FAIL overlap_comb got %b want 1110", o); end
        step();
        checks++;
        if (o_q !== 4'b1110) begin errors++; $display("FAIL overlap_reg got %b want 1110", o_q); end
`ifdef OR_GATE_STATS_EN
        checks++;
        if (cnt_q !== 3'd3) begin errors++; $display("FAIL overlap_cnt got %0d want 3", cnt_q); end
`endif
    endtask

    task automatic test_xprop();
        logic [W-1:0] exp_o;
        x = 4'b1x0z;
        y = 4'b0001;
        exp_o = 4'b1x01;
        #1;
        checks++;
        if (o !== exp_o) begin errors++; $display("FAIL xprop_comb got %b want %b", o, exp_o); end
        x = 4'b0000;
        y = 4'b0000;
        step();
    endtask

    // Random operands, with several intermediate values between edges.
    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            int glitches;
            glitches = $urandom_range(0, 3);
            for (int g = 0; g < glitches; g++) begin
                x = W'($urandom);
                y = W'($urandom);
                #1;
            end
            if (($urandom % 4) == 0) begin
                x = m_oq;
                y = '0;
            end else begin
                x = W'($urandom);
                y = W'($urandom);
            end
            #1;
            checks++;
            if (o !== (x | y)) begin errors++; $display("FAIL rand_comb x=%b y=%b got %b want %b", x, y, o, x | y); end
            step();
            checks++;
            if (o_q !== m_oq || any_q !== m_any || chg_q !== m_chg) begin
                errors++;
                $display("FAIL rand_reg n=%0d got o_q=%b any=%b chg=%b want %b/%b/%b",
                         n, o_q, any_q, chg_q, m_oq, m_any, m_chg);
            end
`ifdef OR_GATE_STATS_EN
            checks++;
            if (int'(cnt_q) != m_cnt) begin errors++; $display("FAIL rand_cnt got %0d want %0d", cnt_q, m_cnt); end
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        x      = '0;
        y      = '0;
        model_reset();
        test_reset();
        test_ones();
        test_swap();
        test_partial();
        test_zero_midreset();
        test_overlap();
        test_xprop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_or_gate_4bit
`default_nettype wire
